multicycle_ctrl: RTL

MULTICYCLE_CTRL -- requirements
Module: multicycle_ctrl

---
 rtl/rv_ctrl_pkg.sv | 88 ++++++++
 rtl/multicycle_ctrl.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/rv_ctrl_pkg.sv
// Shared encodings for the multicycle RV32 control path: states, opcodes,
// datapath mux selects and the bundled control word.
package rv_ctrl_pkg;

  localparam int unsigned STATE_W  = 4;
  localparam int unsigned OPCODE_W = 7;
  localparam int unsigned FUNCT3_W = 3;
  localparam int unsigned SEL_W    = 2;

  typedef enum logic [STATE_W-1:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECR    = 4'd6,
    S_EXECI    = 4'd7,
    S_LUI      = 4'd8,
    S_ALUWB    = 4'd9,
    S_BRANCH   = 4'd10,
    S_JAL      = 4'd11,
    S_JALR     = 4'd12,
    S_JALRWB   = 4'd13,
    S_TRAP     = 4'd14
  } state_e;

  localparam logic [OPCODE_W-1:0] OP_LOAD   = 7'b0000011;
  localparam logic [OPCODE_W-1:0] OP_STORE  = 7'b0100011;
  localparam logic [OPCODE_W-1:0] OP_RTYPE  = 7'b0110011;
  localparam logic [OPCODE_W-1:0] OP_ITYPE  = 7'b0010011;
  localparam logic [OPCODE_W-1:0] OP_AUIPC  = 7'b0010111;
  localparam logic [OPCODE_W-1:0] OP_LUI    = 7'b0110111;
  localparam logic [OPCODE_W-1:0] OP_BRANCH = 7'b1100011;
  localparam logic [OPCODE_W-1:0] OP_JAL    = 7'b1101111;
  localparam logic [OPCODE_W-1:0] OP_JALR   = 7'b1100111;

  localparam logic [FUNCT3_W-1:0] F3_BEQ = 3'b000;
  localparam logic [FUNCT3_W-1:0] F3_BNE = 3'b001;

  localparam logic [SEL_W-1:0] SRCA_PC    = 2'b00;
  localparam logic [SEL_W-1:0] SRCA_OLDPC = 2'b01;
  localparam logic [SEL_W-1:0] SRCA_RS1   = 2'b10;
  localparam logic [SEL_W-1:0] SRCA_ZERO  = 2'b11;

  localparam logic [SEL_W-1:0] SRCB_RS2   = 2'b00;
  localparam logic [SEL_W-1:0] SRCB_IMM   = 2'b01;
  localparam logic [SEL_W-1:0] SRCB_FOUR  = 2'b10;

  localparam logic [SEL_W-1:0] ALUOP_ADD   = 2'b00;
  localparam logic [SEL_W-1:0] ALUOP_SUB   = 2'b01;
  localparam logic [SEL_W-1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [SEL_W-1:0] RES_ALUOUT  = 2'b00;
  localparam logic [SEL_W-1:0] RES_MEMDATA = 2'b01;
  localparam logic [SEL_W-1:0] RES_ALU     = 2'b10;

  typedef struct packed {
    logic             pc_we;
    logic             ir_we;
    logic             mem_req;
    logic             mem_we;
    logic             reg_we;
    logic             adr_src;
    logic [SEL_W-1:0] alu_src_a;
    logic [SEL_W-1:0] alu_src_b;
    logic [SEL_W-1:0] alu_op;
    logic [SEL_W-1:0] result_src;
    logic             illegal;
  } ctrl_t;

  // First execute state for a decoded opcode; anything unrecognised traps.
  function automatic state_e dispatch(input logic [OPCODE_W-1:0] op);
    state_e s;
    case (op)
      OP_LOAD, OP_STORE:  s = S_MEMADR;
      OP_RTYPE:           s = S_EXECR;
      OP_ITYPE, OP_AUIPC: s = S_EXECI;
      OP_LUI:             s = S_LUI;
      OP_BRANCH:          s = S_BRANCH;
      OP_JAL:             s = S_JAL;
      OP_JALR:            s = S_JALR;
      default:            s = S_TRAP;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/multicycle_ctrl.sv
// Multicycle RV32 main control FSM: sequences fetch/decode/execute/writeback
// and drives datapath enables and mux selects as a function of state.
module multicycle_ctrl
  import rv_ctrl_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic [OPCODE_W-1:0] opcode,
  input  logic [FUNCT3_W-1:0] funct3,
  input  logic                zero,
  input  logic                mem_ready,
  output logic                pc_we,
  output logic                ir_we,
  output logic                mem_req,
  output logic                mem_we,
  output logic                reg_we,
  output logic                adr_src,
  output logic [SEL_W-1:0]    alu_src_a,
  output logic [SEL_W-1:0]    alu_src_b,
  output logic [SEL_W-1:0]    alu_op,
  output logic [SEL_W-1:0]    result_src,
  output logic [STATE_W-1:0]  state,
  output logic                illegal
);

  state_e state_q, state_d;
  state_e state_eff;
  ctrl_t  ctrl;

  always_ff @(posedge clk) begin
    if (rst) state_q <= S_FETCH;
    else     state_q <= state_d;
  end

  // While rst is high the outputs present FETCH, with no request or write,
  // so an access caught mid-flight is dropped cleanly.
  always_comb begin
    state_d   = state_q;
    ctrl      = '0;
    state_eff = rst ? S_FETCH : state_q;

    case (state_eff)
      S_FETCH: begin
        ctrl.mem_req    = ~rst;
        ctrl.adr_src    = 1'b0;
        ctrl.alu_src_a  = SRCA_PC;
        ctrl.alu_src_b  = SRCB_FOUR;
        ctrl.alu_op     = ALUOP_ADD;
        ctrl.result_src = RES_ALU;
        if (mem_ready && !rst) begin
          ctrl.ir_we = 1'b1;
          ctrl.pc_we = 1'b1;
          state_d    = S_DECODE;
        end
      end

      S_DECODE: begin
        ctrl.alu_src_a = SRCA_OLDPC;
        ctrl.alu_src_b = SRCB_IMM;
        ctrl.alu_op    = ALUOP_ADD;
        state_d        = dispatch(opcode);
      end

      S_MEMADR: begin
        ctrl.alu_src_a = SRCA_RS1;
        ctrl.alu_src_b = SRCB_IMM;
        ctrl.alu_op    = ALUOP_ADD;
        state_d        = (opcode == OP_LOAD) ? S_MEMREAD : S_MEMWRITE;
      end

      S_MEMREAD: begin
        ctrl.mem_req = 1'b1;
        ctrl.adr_src = 1'b1;
        if (mem_ready) state_d = S_MEMWB;
      end

      S_MEMWB: begin
        ctrl.result_src = RES_MEMDATA;
        ctrl.reg_we     = 1'b1;
        state_d         = S_FETCH;
      end

      S_MEMWRITE: begin
        ctrl.mem_req = 1'b1;
        ctrl.mem_we  = 1'b1;
        ctrl.adr_src = 1'b1;
        if (mem_ready) state_d = S_FETCH;
      end

      S_EXECR: begin
        ctrl.alu_src_a = SRCA_RS1;
        ctrl.alu_src_b = SRCB_RS2;
        ctrl.alu_op    = ALUOP_FUNCT;
        state_d        = S_ALUWB;
      end

      // AUIPC adds the immediate to oldPC; other I-types go through funct decode.
      S_EXECI: begin
        ctrl.alu_src_b = SRCB_IMM;
        if (opcode == OP_AUIPC) begin
          ctrl.alu_src_a = SRCA_OLDPC;
          ctrl.alu_op    = ALUOP_ADD;
        end else begin
          ctrl.alu_src_a = SRCA_RS1;
          ctrl.alu_op    = ALUOP_FUNCT;
        end
        state_d = S_ALUWB;
      end

      S_LUI: begin
        ctrl.alu_src_a = SRCA_ZERO;
        ctrl.alu_src_b = SRCB_IMM;
        ctrl.alu_op    = ALUOP_ADD;
        state_d        = S_ALUWB;
      end

      S_ALUWB: begin
        ctrl.result_src = RES_ALUOUT;
        ctrl.reg_we     = 1'b1;
        state_d         = S_FETCH;
      end

      // Target oldPC+imm was latched in DECODE; only BEQ/BNE can be taken.
      S_BRANCH: begin
        ctrl.alu_src_a  = SRCA_RS1;
        ctrl.alu_src_b  = SRCB_RS2;
        ctrl.alu_op     = ALUOP_SUB;
        ctrl.result_src = RES_ALUOUT;
        case (funct3)
          F3_BEQ:  ctrl.pc_we = zero;
          F3_BNE:  ctrl.pc_we = ~zero;
          default: ctrl.pc_we = 1'b0;
        endcase
        state_d = S_FETCH;
      end

      S_JAL: begin
        ctrl.alu_src_a  = SRCA_OLDPC;
        ctrl.alu_src_b  = SRCB_FOUR;
        ctrl.alu_op     = ALUOP_ADD;
        ctrl.result_src = RES_ALUOUT;
        ctrl.pc_we      = 1'b1;
        state_d         = S_ALUWB;
      end

      S_JALR: begin
        ctrl.alu_src_a  = SRCA_RS1;
        ctrl.alu_src_b  = SRCB_IMM;
        ctrl.alu_op     = ALUOP_ADD;
        ctrl.result_src = RES_ALU;
        ctrl.pc_we      = 1'b1;
        state_d         = S_JALRWB;
      end

      S_JALRWB: begin
        ctrl.alu_src_a  = SRCA_OLDPC;
        ctrl.alu_src_b  = SRCB_FOUR;
        ctrl.alu_op     = ALUOP_ADD;
        ctrl.result_src = RES_ALU;
        ctrl.reg_we     = 1'b1;
        state_d         = S_FETCH;
      end

      S_TRAP: begin
        ctrl.illegal = 1'b1;
        state_d      = S_TRAP;
      end

      default: begin
        ctrl.illegal = 1'b1;
        state_d      = S_TRAP;
      end
    endcase
  end

  assign pc_we      = ctrl.pc_we;
  assign ir_we      = ctrl.ir_we;
  assign mem_req    = ctrl.mem_req;
  assign mem_we     = ctrl.mem_we;
  assign reg_we     = ctrl.reg_we;
  assign adr_src    = ctrl.adr_src;
  assign alu_src_a  = ctrl.alu_src_a;
  assign alu_src_b  = ctrl.alu_src_b;
  assign alu_op     = ctrl.alu_op;
  assign result_src = ctrl.result_src;
  assign illegal    = ctrl.illegal;
  assign state      = STATE_W'(state_q);

endmodule
